// File: rtl/cordic_iter_if.sv
// Handshake and result bundle between the angle normalizer, the CORDIC core and
// the result converter.
interface cordic_iter_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic signed [WIDTH-1:0] angle_in;
    logic [2:0]              flip_in;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] sin_out;
    logic signed [WIDTH-1:0] cos_out;
    logic [2:0]              flip_out;

    modport master (
        output start, angle_in, flip_in,
        input  busy, done, sin_out, cos_out, flip_out
    );

    modport slave (
        input  start, angle_in, flip_in,
        output busy, done, sin_out, cos_out, flip_out
    );
endinterface

// File: rtl/cordic_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, sin/cos of a
// residual angle in [-pi/4, +pi/4]. Constants are scaled for Q2.13 angles / Q1.15 results.
module cordic_iter #(
    parameter int WIDTH = 16,
    parameter int ITER  = 15
) (
    input logic         clk,
    input logic         rst_n,
    cordic_iter_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0]           LAST   = CW'(ITER);
    localparam logic signed [WIDTH+1:0] K_INIT = (WIDTH+2)'(19898);
    localparam logic signed [WIDTH:0]   ZLIM   = (WIDTH+1)'(6434);
    localparam logic signed [WIDTH+1:0] SAT_HI = (WIDTH+2)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH+1:0] SAT_LO = -SAT_HI;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nx;
    logic signed [WIDTH+1:0] x, y;
    logic signed [WIDTH:0]   z;
    logic [CW-1:0]           cnt;
    logic [2:0]              flip;
    logic signed [WIDTH-1:0] sin_r, cos_r;
    logic [2:0]              flip_r;
    logic                    done_r;

    logic signed [WIDTH:0]   ang_ext, ang_clamped;
    logic signed [WIDTH+1:0] xs, ys, x_nx, y_nx;
    logic signed [WIDTH:0]   z_nx;

    function automatic logic signed [WIDTH:0] atan_lut(input logic [CW-1:0] i);
        int r;
        case (int'(i))
            0:       r = 6434;
            1:       r = 3798;
            2:       r = 2007;
            3:       r = 1019;
            4:       r = 511;
            5:       r = 256;
            6:       r = 128;
            7:       r = 64;
            8:       r = 32;
            9:       r = 16;
            10:      r = 8;
            11:      r = 4;
            12:      r = 2;
            13:      r = 1;
            default: r = 0;
        endcase
        return (WIDTH+1)'(r);
    endfunction

    // Results are symmetric: -2^(WIDTH-1) is never emitted.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
        if (v > SAT_HI)
            return SAT_HI[WIDTH-1:0];
        else if (v < SAT_LO)
            return SAT_LO[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    always_comb begin
        ang_ext = {bus.angle_in[WIDTH-1], bus.angle_in};
        if (ang_ext > ZLIM)
            ang_clamped = ZLIM;
        else if (ang_ext < -ZLIM)
            ang_clamped = -ZLIM;
        else
            ang_clamped = ang_ext;
    end

    always_comb begin
        xs = x >>> cnt;
        ys = y >>> cnt;
        if (!z[WIDTH]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - atan_lut(cnt);
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + atan_lut(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            z      <= '0;
            cnt    <= '0;
            flip   <= '0;
            sin_r  <= '0;
            cos_r  <= '0;
            flip_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x    <= K_INIT;
                        y    <= '0;
                        z    <= ang_clamped;
                        flip <= bus.flip_in;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    // The cycle after the last micro-rotation publishes the result.
                    if (cnt == LAST) begin
                        sin_r  <= sat(y);
                        cos_r  <= sat(x);
                        flip_r <= flip;
                        done_r <= 1'b1;
                    end else begin
                        x   <= x_nx;
                        y   <= y_nx;
                        z   <= z_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done_r;
    assign bus.sin_out  = sin_r;
    assign bus.cos_out  = cos_r;
    assign bus.flip_out = flip_r;
endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: a schedule/arithmetic reference model checked
// every cycle, plus hand-computed literal expectations for the key angles.
module tb_cordic_iter;
    localparam int WIDTH = 16;
    localparam int ITER  = 15;
    localparam int TOL   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_iter_if #(.WIDTH(WIDTH)) bus ();

    cordic_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    function automatic int atan_q13(input int i);
        int t[15] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};
        return (i < 15) ? t[i] : 0;
    endfunction

    function automatic int sat16(input int v);
        return (v > 32767) ? 32767 : (v < -32767) ? -32767 : v;
    endfunction

    // Rotation-mode recurrence on plain integers, starting from x=K, y=0.
    task automatic ref_cordic(input int ang, output int s, output int c);
        int x, y, z, xs, ys;
        z = (ang > 6434) ? 6434 : (ang < -6434) ? -6434 : ang;
        x = 19898;
        y = 0;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - atan_q13(i);
            end else begin
                x = x + ys; y = y - xs; z = z + atan_q13(i);
            end
        end
        s = sat16(y);
        c = sat16(x);
    endtask

    // Schedule model: a result appears ITER+1 clocks after its accept.
    int m_left = 0, m_acc = 0;
    int m_done = 0, m_sin = 0, m_cos = 0, m_flip = 0;
    int p_sin = 0, p_cos = 0, p_flip = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_sin = 0; m_cos = 0; m_flip = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_sin = p_sin; m_cos = p_cos; m_flip = p_flip;
                end
            end else if (bus.start) begin
                ref_cordic(int'(bus.angle_in), p_sin, p_cos);
                p_flip = int'(bus.flip_in);
                m_left = ITER + 1;
                m_acc++;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("busy", int'(bus.busy), (m_left > 0) ? 1 : 0);
        chk("done", int'(bus.done), m_done);
        chk("sin_out", int'(bus.sin_out), m_sin);
        chk("cos_out", int'(bus.cos_out), m_cos);
        chk("flip_out", int'(bus.flip_out), m_flip);
        if (bus.done) n_done++;
    end

    task automatic run_one(input int ang, input int fl, output int lat, output int bcnt,
                           output int s, output int c, output int f);
        bit got;
        got = 0; lat = 0; s = 0; c = 0; f = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.angle_in = WIDTH'(ang); bus.flip_in = 3'(fl);
        @(posedge clk); #2;
        bus.start = 1'b0;
        bcnt = int'(bus.busy);
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #2;
            lat++;
            bcnt += int'(bus.busy);
            if (bus.done) begin
                got = 1;
                s = int'(bus.sin_out); c = int'(bus.cos_out); f = int'(bus.flip_out);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    int lat, bcnt, s, c, f, es, ec, nd, target, d0;

    initial begin
        bus.start = 1'b0; bus.angle_in = '0; bus.flip_in = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sin", int'(bus.sin_out), 0);
        chk("rst_cos", int'(bus.cos_out), 0);
        chk("rst_flip", int'(bus.flip_out), 0);

        // Zero angle: latency, busy length, literal ranges for DUT and model.
        run_one(0, 0, lat, bcnt, s, c, f);
        chk("t1_latency", lat, 16);
        chk("t1_busy_cycles", bcnt, 16);
        chk_range("t1_sin", s, -TOL, TOL);
        chk_range("t1_cos", c, 32767 - TOL, 32767);
        ref_cordic(0, es, ec);
        chk_range("model_sin0", es, -TOL, TOL);
        chk_range("model_cos0", ec, 32767 - TOL, 32767);

        // +/- pi/4: sin = cos = 23170 in magnitude.
        run_one(6434, 1, lat, bcnt, s, c, f);
        chk_range("t2_sin_pos", s, 23170 - TOL, 23170 + TOL);
        chk_range("t2_cos_pos", c, 23170 - TOL, 23170 + TOL);
        chk("t2_flip", f, 1);
        ref_cordic(6434, es, ec);
        chk_range("model_sin_pi4", es, 23170 - TOL, 23170 + TOL);
        run_one(-6434, 0, lat, bcnt, s, c, f);
        chk_range("t2_sin_neg", s, -23170 - TOL, -23170 + TOL);
        chk_range("t2_cos_neg", c, 23170 - TOL, 23170 + TOL);

        // Out-of-range angles clamp to +/- pi/4.
        run_one(8000, 2, lat, bcnt, s, c, f);
        ref_cordic(6434, es, ec);
        chk("t3_sin_clamp_pos", s, es);
        chk("t3_cos_clamp_pos", c, ec);
        run_one(-8000, 2, lat, bcnt, s, c, f);
        ref_cordic(-6434, es, ec);
        chk("t3_sin_clamp_neg", s, es);
        chk("t3_cos_clamp_neg", c, ec);

        // Start while busy is ignored; flip code travels with the result.
        @(negedge clk);
        bus.start = 1'b1; bus.angle_in = WIDTH'(1000); bus.flip_in = 3'b101;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        bus.start = 1'b1; bus.angle_in = WIDTH'(-3000); bus.flip_in = 3'b010;
        @(posedge clk); #2;
        bus.start = 1'b0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #2;
            if (bus.done) begin
                nd++;
                s = int'(bus.sin_out); c = int'(bus.cos_out); f = int'(bus.flip_out);
            end
        end
        ref_cordic(1000, es, ec);
        chk("t4_done_count", nd, 1);
        chk("t4_sin", s, es);
        chk("t4_cos", c, ec);
        chk("t4_flip", f, 5);

        // Reset at iteration 7 aborts without a done.
        @(negedge clk);
        bus.start = 1'b1; bus.angle_in = WIDTH'(2000); bus.flip_in = 3'b110;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_done", int'(bus.done), 0);
        chk("t5_sin", int'(bus.sin_out), 0);
        chk("t5_cos", int'(bus.cos_out), 0);
        chk("t5_flip", int'(bus.flip_out), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        d0 = n_done;
        repeat (30) @(posedge clk);
        #3;
        chk("t5_no_done", n_done - d0, 0);
        run_one(2000, 6, lat, bcnt, s, c, f);
        ref_cordic(2000, es, ec);
        chk("t5_restart_latency", lat, 16);
        chk("t5_restart_sin", s, es);
        chk("t5_restart_cos", c, ec);
        chk("t5_restart_flip", f, 6);

        // Start held high across a 64-angle sweep: back-to-back results.
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k < 64; k++) begin
            bit ok;
            bus.angle_in = WIDTH'(-6434 + (k * 12868) / 63);
            bus.flip_in  = 3'(k);
            target = m_acc + 1;
            ok = 0;
            for (int w = 0; w < 40 && !ok; w++) begin
                @(negedge clk);
                if (m_acc >= target) ok = 1;
            end
            if (!ok) chk("t6_accept_timeout", 0, 1);
        end
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        chk("t6_done_count", n_done - d0, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
